// File: rtl/btn_event_gen_pkg.sv
// Shared definitions for button-driven blocks.
//   - Hold FSM state encoding (IDLE/WAIT/RPT, 2 bits).
//   - Default timing constants for the button front end.
package btn_event_gen_pkg;

  typedef logic [1:0] hold_state_t;

  localparam hold_state_t StIdle = 2'b00;
  localparam hold_state_t StWait = 2'b01;
  localparam hold_state_t StRpt  = 2'b10;

  localparam int unsigned DefNbtn      = 4;
  localparam int unsigned DefSampleDiv = 125000;  // 1 ms at 125 MHz
  localparam int unsigned DefStableCnt = 10;
  localparam int unsigned DefLongCnt   = 1000;
  localparam int unsigned DefRepeatCnt = 200;

  // Width needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_event_ch.sv
// One button channel: debounce counter, debounced level, hold FSM and
// registered 1-CLK event pulses.
//   clk_i      system clock
//   rst_i      synchronous, active-high reset
//   tick_i     shared sample tick (1 CLK wide)
//   btn_i      synchronised button level, 1 = pressed
//   level_o    debounced level
//   press_o    pulse on level 0->1
//   release_o  pulse on level 1->0
//   longp_o    pulse after LONG_CNT ticks of continuous hold
//   repeat_o   pulse every REPEAT_CNT ticks after longp_o while held
module btn_event_ch
  import btn_event_gen_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DefStableCnt,
  parameter int unsigned LONG_CNT   = DefLongCnt,
  parameter int unsigned REPEAT_CNT = DefRepeatCnt
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic longp_o,
  output logic repeat_o
);

  localparam int unsigned SW   = cnt_width(STABLE_CNT);
  localparam int unsigned HMax = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int unsigned HW   = cnt_width(HMax);

  // Comparing against N-1 is the same as testing cnt+1 == N without overflow.
  localparam logic [SW-1:0] StableLast = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] LongLast   = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] RptLast    = HW'(REPEAT_CNT - 1);
  localparam logic [HW-1:0] HSat       = HW'(HMax);

  logic [SW-1:0] scnt_q, scnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  hold_state_t   st_q, st_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          longp_q, longp_d;
  logic          repeat_q, repeat_d;
  logic          rise, fall;
  logic [HW-1:0] hcnt_inc;

  // Debounce: only a run of STABLE_CNT consecutive differing samples flips level.
  always_comb begin
    level_d = level_q;
    scnt_d  = scnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (tick_i) begin
      if (btn_i != level_q) begin
        if (scnt_q == StableLast) begin
          level_d = ~level_q;
          scnt_d  = '0;
          rise    = ~level_q;
          fall    = level_q;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end else begin
        scnt_d = '0;
      end
    end
    press_d   = rise;
    release_d = fall;
  end

  assign hcnt_inc = (hcnt_q == HSat) ? hcnt_q : hcnt_q + HW'(1);

  // Hold FSM reacts on the same edge that updates level, so the pulse that
  // starts a hold (press) never coincides with a tick-driven one.
  always_comb begin
    st_d     = st_q;
    hcnt_d   = hcnt_q;
    longp_d  = 1'b0;
    repeat_d = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (rise) begin
          st_d   = StWait;
          hcnt_d = '0;
        end
      end
      StWait: begin
        if (fall) begin
          st_d   = StIdle;
          hcnt_d = '0;
        end else if (tick_i) begin
          if (hcnt_q == LongLast) begin
            longp_d = 1'b1;
            hcnt_d  = '0;
            st_d    = StRpt;
          end else begin
            hcnt_d = hcnt_inc;
          end
        end
      end
      StRpt: begin
        if (fall) begin
          st_d   = StIdle;
          hcnt_d = '0;
        end else if (tick_i) begin
          if (hcnt_q == RptLast) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_inc;
          end
        end
      end
      default: begin
        st_d   = StIdle;
        hcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scnt_q    <= '0;
      hcnt_q    <= '0;
      st_q      <= StIdle;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      longp_q   <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      scnt_q    <= scnt_d;
      hcnt_q    <= hcnt_d;
      st_q      <= st_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      longp_q   <= longp_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign longp_o   = longp_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_event_gen.sv
// Multi-button front end: 2-FF synchroniser per button, one shared sample-tick
// divider, and an independent debounce/hold channel per button.
//   CLK      system clock
//   RST      synchronous, active-high reset
//   BTNIN    raw asynchronous buttons, 1 = pressed
//   LEVEL    debounced button state
//   PRESS    1-CLK pulse on LEVEL 0->1
//   RELEASE  1-CLK pulse on LEVEL 1->0
//   LONGP    1-CLK pulse after LONG_CNT ticks held
//   REPEAT   1-CLK pulse every REPEAT_CNT ticks after LONGP while held
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int unsigned NBTN       = DefNbtn,
  parameter int unsigned SAMPLE_DIV = DefSampleDiv,
  parameter int unsigned STABLE_CNT = DefStableCnt,
  parameter int unsigned LONG_CNT   = DefLongCnt,
  parameter int unsigned REPEAT_CNT = DefRepeatCnt
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTNIN,
  output logic [NBTN-1:0] LEVEL,
  output logic [NBTN-1:0] PRESS,
  output logic [NBTN-1:0] RELEASE,
  output logic [NBTN-1:0] LONGP,
  output logic [NBTN-1:0] REPEAT
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] DivLast = TW'(SAMPLE_DIV - 1);

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [TW-1:0]   div_q, div_d;
  logic            tick;

  assign tick = (div_q == DivLast);

  always_comb begin
    div_d = tick ? '0 : div_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= BTNIN;
      sync2_q <= sync1_q;
      div_q   <= div_d;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_event_ch #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_CNT  (LONG_CNT),
      .REPEAT_CNT(REPEAT_CNT)
    ) u_ch (
      .clk_i    (CLK),
      .rst_i    (RST),
      .tick_i   (tick),
      .btn_i    (sync2_q[i]),
      .level_o  (LEVEL[i]),
      .press_o  (PRESS[i]),
      .release_o(RELEASE[i]),
      .longp_o  (LONGP[i]),
      .repeat_o (REPEAT[i])
    );
  end

endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;

  localparam int NB   = 4;
  localparam int DIV  = 4;
  localparam int STAB = 3;
  localparam int LNG  = 8;
  localparam int RPT  = 4;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KLongp   = 2;
  localparam int KRepeat  = 3;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] BTNIN;
  logic [NB-1:0] LEVEL, PRESS, RELEASE, LONGP, REPEAT;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  bit   mon_en = 1'b0;
  ev_t  exp_q[$];
  int   last_press[NB];
  int   lp_seen[NB];
  int   rpt_seen[NB];
  logic [3:0] mon_p;
  int   mon_found;

  btn_event_gen #(
    .NBTN      (NB),
    .SAMPLE_DIV(DIV),
    .STABLE_CNT(STAB),
    .LONG_CNT  (LNG),
    .REPEAT_CNT(RPT)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .BTNIN  (BTNIN),
    .LEVEL  (LEVEL),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .LONGP  (LONGP),
    .REPEAT (REPEAT)
  );

  always #5 CLK = ~CLK;

  // cyc == k after the k-th rising edge following the last reset edge.
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic string kind_name(input int k);
    case (k)
      KPress:   return "PRESS";
      KRelease: return "RELEASE";
      KLongp:   return "LONGP";
      default:  return "REPEAT";
    endcase
  endfunction

  // First edge index >= b on which the channels act on a sample tick.
  function automatic int next_tick(input int b);
    return ((b + DIV - 1) / DIV) * DIV;
  endfunction

  task automatic push_ev(input int c, input int k, input int t);
    ev_t e;
    e.ch   = c;
    e.kind = k;
    e.cyc  = t;
    exp_q.push_back(e);
  endtask

  // Button c driven high after edge a_p and low after edge a_r.
  // Sync adds 2 edges, so the first sample can be at edge a+3; LEVEL flips on
  // the STAB-th differing tick.
  task automatic push_hold(input int c, input int a_p, input int a_r);
    int p, r;
    p = next_tick(a_p + 3) + (STAB - 1) * DIV;
    r = next_tick(a_r + 3) + (STAB - 1) * DIV;
    push_ev(c, KPress, p);
    if (p + LNG * DIV < r) push_ev(c, KLongp, p + LNG * DIV);
    for (int t = p + (LNG + RPT) * DIV; t < r; t += RPT * DIV) push_ev(c, KRepeat, t);
    push_ev(c, KRelease, r);
  endtask

  // Scoreboard monitor: every observed pulse must match a queued expectation
  // for the same channel, kind and cycle; overdue expectations are misses.
  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      for (int c = 0; c < NB; c++) begin
        mon_p = {REPEAT[c], LONGP[c], RELEASE[c], PRESS[c]};
        if (mon_p != 4'b0000) begin
          checks++;
          if (!$onehot(mon_p)) begin
            errors++;
            $display("FAIL onehot ch=%0d cyc=%0d: pulses=%b, required at most one", c, cyc,
                     mon_p);
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (mon_p[k]) begin
            if (k == KPress)  last_press[c] = cyc;
            if (k == KLongp)  lp_seen[c]++;
            if (k == KRepeat) rpt_seen[c]++;
            mon_found = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (exp_q[i].ch == c && exp_q[i].kind == k && exp_q[i].cyc == cyc) mon_found = i;
            end
            checks++;
            if (mon_found < 0) begin
              errors++;
              $display("FAIL unexpected_%s ch=%0d cyc=%0d: pulse seen, required none",
                       kind_name(k), c, cyc);
            end else begin
              exp_q.delete(mon_found);
            end
          end
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_%s ch=%0d: no pulse seen, required at cyc=%0d",
                   kind_name(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_level(input string name, input logic [NB-1:0] req);
    checks++;
    if (LEVEL !== req) begin
      errors++;
      $display("FAIL %s_level: LEVEL=%b, required %b", name, LEVEL, req);
    end
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    BTNIN = '0;
    wait_cyc(4);
    checks++;
    if ({LEVEL, PRESS, RELEASE, LONGP, REPEAT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %b %b %b %b %b, required all 0", LEVEL, PRESS, RELEASE,
               LONGP, REPEAT);
    end
    RST    = 1'b0;
    mon_en = 1'b1;
    wait_cyc(20);
    check_level("reset_idle", 4'b0000);
    check_drained("reset");
  endtask

  task automatic test_clean_press();
    int a;
    a = cyc;
    push_hold(0, a, a + 20);
    BTNIN[0] = 1'b1;
    wait_cyc(16);
    check_level("clean_held", 4'b0001);
    checks++;
    if (last_press[0] - a < 10 || last_press[0] - a > 15) begin
      errors++;
      $display("FAIL clean_latency: press %0d CLK after edge, required 10..15",
               last_press[0] - a);
    end
    wait_cyc(4);
    BTNIN[0] = 1'b0;
    wait_cyc(24);
    check_level("clean_released", 4'b0000);
    check_drained("clean");
  endtask

  task automatic test_glitch();
    bit bad;
    bad      = 1'b0;
    BTNIN[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (LEVEL[1] !== 1'b0) bad = 1'b1;
    end
    BTNIN[1] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (LEVEL[1] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL glitch_level: LEVEL[1] went to 1, required 0 throughout");
    end
    check_drained("glitch");
  endtask

  task automatic test_long_hold();
    int a, lp0, rp0;
    a   = cyc;
    lp0 = lp_seen[2];
    rp0 = rpt_seen[2];
    push_hold(2, a, a + 248);
    BTNIN[2] = 1'b1;
    wait_cyc(248);
    check_level("long_held", 4'b0100);
    BTNIN[2] = 1'b0;
    wait_cyc(24);
    checks++;
    if (lp_seen[2] - lp0 != 1) begin
      errors++;
      $display("FAIL long_longp_count: %0d, required 1", lp_seen[2] - lp0);
    end
    checks++;
    if (rpt_seen[2] - rp0 != 13) begin
      errors++;
      $display("FAIL long_repeat_count: %0d, required 13", rpt_seen[2] - rp0);
    end
    check_level("long_released", 4'b0000);
    check_drained("long");
  endtask

  task automatic test_simultaneous();
    int a, p;
    a = cyc;
    p = next_tick(a + 3) + (STAB - 1) * DIV;
    push_hold(0, a, a + 20);
    push_hold(3, a, a + 20);
    BTNIN = 4'b1001;
    wait_cyc(p - a);
    checks++;
    if (PRESS !== 4'b1001) begin
      errors++;
      $display("FAIL simul_press: PRESS=%b, required 1001", PRESS);
    end
    wait_cyc(20 - (p - a));
    BTNIN = 4'b0000;
    wait_cyc(24);
    check_drained("simul");
  endtask

  task automatic test_release_at_long();
    int a, lp0;
    a   = cyc;
    lp0 = lp_seen[2];
    push_hold(2, a, a + LNG * DIV);
    BTNIN[2] = 1'b1;
    wait_cyc(LNG * DIV);
    BTNIN[2] = 1'b0;
    wait_cyc(24);
    checks++;
    if (lp_seen[2] != lp0) begin
      errors++;
      $display("FAIL edge_longp: %0d LONGP pulses, required 0", lp_seen[2] - lp0);
    end
    check_drained("edge");
  endtask

  task automatic test_reset_mid_hold();
    int a, p;
    a = cyc;
    p = next_tick(a + 3) + (STAB - 1) * DIV;
    push_ev(0, KPress, p);
    push_ev(0, KLongp, p + LNG * DIV);
    BTNIN[0] = 1'b1;
    wait_cyc(p + LNG * DIV + 8 - a);
    check_level("rpt_held", 4'b0001);
    check_drained("rpt_pre");
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({LEVEL, PRESS, RELEASE, LONGP, REPEAT} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: %b %b %b %b %b, required all 0", LEVEL, PRESS,
               RELEASE, LONGP, REPEAT);
    end
    RST = 1'b0;
    push_hold(0, 0, 20);
    wait_cyc(8);
    check_level("midrst_debouncing", 4'b0000);
    wait_cyc(12);
    check_level("midrst_repressed", 4'b0001);
    BTNIN[0] = 1'b0;
    wait_cyc(24);
    check_drained("midrst");
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      last_press[i] = -1000;
      lp_seen[i]    = 0;
      rpt_seen[i]   = 0;
    end
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_hold();
    test_simultaneous();
    test_release_at_long();
    test_reset_mid_hold();
    wait_cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
